fetch_ctrl: RTL
===============

// Module: fetch_ctrl
// PURPOSE
//  Fetch sequencer between PredictUnit and the instruction SRAM port of mycpu_top.
//  Accepts predicted fetch blocks (start addr + FETCH_W-bit slot-valid mask) via valid/ready.
//  Issues one SRAM word read per valid slot and buffers {pc,inst} in an instruction queue for decode.
//  Drives PredictUnit's next_ready; a backend redirect flushes all fetch state.
// PARAMETERS
//  ADDR_W    32  address/pc width
//  FETCH_W   4   slots per fetch block (pred_mask width)
//  IQ_DEPTH  8   instruction queue entries, power of two
// PORTS
//  clk             in   1        core clock
//  resetn          in   1        async active-low reset
//  pred_valid      in   1        PredictUnit block valid (predict_unit_out_valid)
//  pred_addr       in   ADDR_W   block start address, word aligned (fetch_start_addr)
//  pred_mask       in   FETCH_W  slot i valid -> fetch pred_addr+4*i (fetch_pos_valid)
//  pred_ready      out  1        block accepted when pred_valid&&pred_ready (next_ready)
//  redirect        in   1        backend flush, one-cycle pulse
//  inst_sram_req   out  1        read strobe; SRAM returns rdata next cycle
//  inst_sram_we    out  1        tied 0
//  inst_sram_addr  out  ADDR_W   read address
//  inst_sram_rdata in   32       read data, valid one cycle after req
//  iq_valid        out  1        queue head valid
//  iq_pc           out  ADDR_W   head pc
//  iq_inst         out  32       head instruction
//  iq_ready        in   1        decode pops head when iq_valid&&iq_ready
// BEHAVIOUR
//  Reset: state IDLE, pred_ready=1 once resetn high, inst_sram_req=0, inst_sram_addr=0, iq empty, iq_valid=0.
//  FSM IDLE: pred_ready=!redirect. On accept latch addr/mask; mask==0 -> stay IDLE, else -> ISSUE.
//  FSM ISSUE: pred_ready=0; each cycle with room issue lowest remaining set slot, clear its bit;
//   last bit issued -> IDLE (next block acceptable following cycle).
//  Room: iq_count + resp_pending < IQ_DEPTH; else req=0, state held (stall).
//  Response: resp_pending set on req, rdata pushed with its pc next cycle unless killed.
//  Latency: accept cycle T -> req T+1 -> push at end of T+2 -> iq_valid T+3 (empty queue).
//  Push and pop same cycle: count unchanged, both take effect; pop on empty ignored.
//  Queue pointers wrap modulo IQ_DEPTH; iq_count width clog2(IQ_DEPTH)+1.
//  Redirect: same cycle req=0, pred_ready=0; next cycle IDLE, queue empty, pending response
//   discarded; redirect wins over simultaneous accept/push/pop.
//  Max one outstanding SRAM read; addr arithmetic modulo 2^ADDR_W.
// CONFIGURATION
//  FETCH_CTRL_PERF_EN defined: adds outputs perf_blocks[31:0] (accepted non-empty blocks) and
//   perf_stalls[31:0] (ISSUE cycles with req=0); both reset 0, wrap, cleared by resetn only.
//  Undefined: ports and counters absent; other behaviour identical.
// STRUCTURE
//  fetch_pkg: FETCH_W/IQ_DEPTH defaults, fetch_state_t enum {IDLE,ISSUE}, iq_entry_t {pc,inst}.
//  Sub-module fetch_iq: sync FIFO of iq_entry_t, push/pop/flush, count, async active-low reset.
//  fetch_ctrl: FSM, slot priority encoder, response tracking, fetch_iq instance.
// TESTING
//  Block 0x1C000000 mask 4'b1111, iq_ready=1 -> reqs at 0x1C000000..0C on 4 consecutive cycles,
//   iq pops same pcs in order; pred_ready low during ISSUE.
//  Mask 4'b1010 at 0x1C000010 -> exactly two reqs, 0x1C000014 then 0x1C00001C.
//  Mask 4'b0000 -> accepted, no req, pred_ready stays 1.
//  iq_ready=0, two full blocks -> 8 entries then req held 0, pred_ready 0; one pop -> one new req.
//  Redirect the cycle after 2nd req of 4-slot block -> no further req, 2nd response dropped,
//   iq_valid=0 next cycle, pred_ready=1 next cycle.
//  resetn low mid-ISSUE with pending response -> all outputs at reset values asynchronously,
//   no push after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the fetch sequencer and its instruction queue.
package fetch_pkg;

  localparam int ADDR_W_DEF   = 32;
  localparam int FETCH_W_DEF  = 4;
  localparam int IQ_DEPTH_DEF = 8;

  typedef enum logic {
    IDLE,
    ISSUE
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [31:0]           inst;
  } iq_entry_t;

endpackage

// File: rtl/fetch_iq.sv
// Instruction queue: synchronous FIFO of {pc,inst} entries with push/pop/flush and occupancy count.
module fetch_iq
  import fetch_pkg::*;
#(
  parameter  int IQ_DEPTH = IQ_DEPTH_DEF,
  localparam int PTR_W    = $clog2(IQ_DEPTH),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  iq_entry_t        push_entry,
  input  logic             pop,
  input  logic             flush,
  output logic             head_valid,
  output iq_entry_t        head_entry,
  output logic [CNT_W-1:0] count
);

  iq_entry_t        mem_q [IQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && (count_q != '0) && !flush;

  // Pointers wrap naturally because the depth is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head_valid = (count_q != '0);
  assign head_entry = mem_q[rd_ptr_q];
  assign count      = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: turns predicted fetch blocks into per-slot SRAM reads feeding the instruction queue.
// Optional FETCH_CTRL_PERF_EN adds perf_blocks / perf_stalls counters.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int FETCH_W  = FETCH_W_DEF,
  parameter int IQ_DEPTH = IQ_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               pred_valid,
  input  logic [ADDR_W-1:0]  pred_addr,
  input  logic [FETCH_W-1:0] pred_mask,
  output logic               pred_ready,
  input  logic               redirect,
  output logic               inst_sram_req,
  output logic               inst_sram_we,
  output logic [ADDR_W-1:0]  inst_sram_addr,
  input  logic [31:0]        inst_sram_rdata,
  output logic               iq_valid,
  output logic [ADDR_W-1:0]  iq_pc,
  output logic [31:0]        iq_inst,
  input  logic               iq_ready
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]        perf_blocks,
  output logic [31:0]        perf_stalls
`endif
);

  localparam int CNT_W  = $clog2(IQ_DEPTH) + 1;
  localparam int SLOT_W = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [FETCH_W-1:0] mask_q, mask_d, mask_clr;
  logic               resp_pending_q, resp_pending_d;
  logic [ADDR_W-1:0]  resp_pc_q, resp_pc_d;
  logic [SLOT_W-1:0]  slot;
  logic               slot_found;
  logic [ADDR_W-1:0]  slot_addr;
  logic [CNT_W:0]     occupancy;
  logic               room;
  logic [CNT_W-1:0]   iq_count;
  iq_entry_t          push_entry, head_entry;

  // Lowest remaining set slot is issued first.
  always_comb begin
    slot       = '0;
    slot_found = 1'b0;
    for (int i = 0; i < FETCH_W; i++) begin
      if (mask_q[i] && !slot_found) begin
        slot       = SLOT_W'(i);
        slot_found = 1'b1;
      end
    end
  end

  assign mask_clr  = mask_q & ~(FETCH_W'(1) << slot);
  assign slot_addr = addr_q + (ADDR_W'(slot) << 2);

  // An in-flight read has already claimed a queue slot.
  assign occupancy = {1'b0, iq_count} + (CNT_W+1)'(resp_pending_q);
  assign room      = occupancy < (CNT_W+1)'(IQ_DEPTH);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    mask_d        = mask_q;
    resp_pc_d     = resp_pc_q;
    pred_ready    = 1'b0;
    inst_sram_req = 1'b0;
    case (state_q)
      IDLE: begin
        pred_ready = !redirect;
        if (pred_valid && !redirect) begin
          addr_d = pred_addr;
          mask_d = pred_mask;
          if (pred_mask != '0) state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (redirect) begin
          state_d = IDLE;
        end else if (room) begin
          inst_sram_req = 1'b1;
          mask_d        = mask_clr;
          resp_pc_d     = slot_addr;
          if (mask_clr == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    resp_pending_d = inst_sram_req;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      mask_q         <= '0;
      resp_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      mask_q         <= mask_d;
      resp_pending_q <= resp_pending_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q    <= addr_d;
    resp_pc_q <= resp_pc_d;
  end

  assign inst_sram_we   = 1'b0;
  assign inst_sram_addr = inst_sram_req ? slot_addr : '0;

  assign push_entry.pc   = resp_pc_q;
  assign push_entry.inst = inst_sram_rdata;

  fetch_iq #(.IQ_DEPTH(IQ_DEPTH)) u_iq (
    .clk        (clk),
    .resetn     (resetn),
    .push       (resp_pending_q && !redirect),
    .push_entry (push_entry),
    .pop        (iq_ready && !redirect),
    .flush      (redirect),
    .head_valid (iq_valid),
    .head_entry (head_entry),
    .count      (iq_count)
  );

  assign iq_pc   = head_entry.pc;
  assign iq_inst = head_entry.inst;

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_blocks_q, perf_blocks_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  always_comb begin
    perf_blocks_d = perf_blocks_q;
    perf_stalls_d = perf_stalls_q;
    if (state_q == IDLE && pred_valid && pred_ready && pred_mask != '0)
      perf_blocks_d = perf_blocks_q + 32'd1;
    if (state_q == ISSUE && !inst_sram_req)
      perf_stalls_d = perf_stalls_q + 32'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_blocks_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_blocks_q <= perf_blocks_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_blocks = perf_blocks_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule
